// File: rtl/bcd_sched_pkg.sv
// Shared types and constants for the BCD conversion scheduler.
// Optional leading-zero blanking is selected with BCD_SCHED_LZ_BLANK_EN.
package bcd_sched_pkg;
  typedef enum logic [1:0] {IDLE, CONVERT, OUTPUT} state_t;

  localparam int         ITER_CNT    = 8;
  localparam logic [3:0] DIGIT_BLANK = 4'hF;
  localparam int         SHIFT_W     = 20;
endpackage

// File: rtl/bcd_dabble_step.sv
// One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift left.
module bcd_dabble_step
  import bcd_sched_pkg::*;
(
  input  logic [SHIFT_W-1:0] shift_in,
  output logic [SHIFT_W-1:0] shift_out
);
  logic [SHIFT_W-1:0] adj;

  assign adj[7:0] = shift_in[7:0];

  // BCD nibbles occupy [11:8], [15:12], [19:16]; the low byte is the binary source
  for (genvar gi = 0; gi < 3; gi++) begin : g_nib
    logic [3:0] nib;
    assign nib = shift_in[8+4*gi +: 4];
    assign adj[8+4*gi +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
  end

  assign shift_out = {adj[SHIFT_W-2:0], 1'b0};
endmodule

// File: rtl/bcd_convert_scheduler.sv
// Round-robin scheduler sharing one sequential binary-to-BCD converter.
// Define BCD_SCHED_LZ_BLANK_EN to blank leading zero digits as 4'hF.
module bcd_convert_scheduler
  import bcd_sched_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] data_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic                 busy_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ID_W-1:0]      out_id_o,
  output logic [3:0]           hundreds_o,
  output logic [3:0]           tens_o,
  output logic [3:0]           ones_o
);
  localparam int CW    = ID_W + 1;
  localparam int ITER_W = $clog2(ITER_CNT);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ITER_W-1:0]   iter_cnt;
  logic [SHIFT_W-1:0]  shift_reg;
  logic [SHIFT_W-1:0]  step_out;

  logic [CW-1:0]       cand;
  logic [ID_W-1:0]     grant_idx;
  logic                grant_valid;
  logic [ID_W-1:0]     rr_next;

  bcd_dabble_step u_step (
    .shift_in  (shift_reg),
    .shift_out (step_out)
  );

  // Scan downward in offset so the closest requester at/above rr_ptr wins last
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = {1'b0, rr_ptr} + CW'(k);
      if (cand >= CW'(NUM_REQ)) cand = cand - CW'(NUM_REQ);
      if (req_i[cand[ID_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
  end

  assign rr_next = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  function automatic logic [11:0] pack_digits(input logic [SHIFT_W-1:0] s);
    logic [3:0] h, t, o;
    h = s[19:16];
    t = s[15:12];
    o = s[11:8];
`ifdef BCD_SCHED_LZ_BLANK_EN
    if (h == 4'd0) begin
      h = DIGIT_BLANK;
      if (t == 4'd0) t = DIGIT_BLANK;
    end
`endif
    return {h, t, o};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      iter_cnt    <= '0;
      shift_reg   <= '0;
      ack_o       <= '0;
      busy_o      <= 1'b0;
      out_valid_o <= 1'b0;
      out_id_o    <= '0;
      hundreds_o  <= '0;
      tens_o      <= '0;
      ones_o      <= '0;
    end else begin
      ack_o <= '0;
      case (state)
        IDLE: begin
          if (grant_valid) begin
            shift_reg <= {12'd0, data_i[{grant_idx, 3'b000} +: 8]};
            iter_cnt  <= '0;
            ack_o     <= NUM_REQ'(1) << grant_idx;
            out_id_o  <= grant_idx;
            rr_ptr    <= rr_next;
            busy_o    <= 1'b1;
            state     <= CONVERT;
          end
        end
        CONVERT: begin
          shift_reg <= step_out;
          iter_cnt  <= iter_cnt + 1'b1;
          if (iter_cnt == ITER_W'(ITER_CNT - 1)) begin
            {hundreds_o, tens_o, ones_o} <= pack_digits(step_out);
            out_valid_o <= 1'b1;
            state       <= OUTPUT;
          end
        end
        OUTPUT: begin
          if (out_ready_i) begin
            out_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bcd_convert_scheduler.sv
// Self-checking bench for bcd_convert_scheduler: vector table, scoreboard, corner sequences.
module tb_bcd_convert_scheduler;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_i;
  logic [8*N-1:0] data_i;
  logic [N-1:0]   ack_o;
  logic           busy_o;
  logic           out_valid_o;
  logic           out_ready_i;
  logic [1:0]     out_id_o;
  logic [3:0]     hundreds_o, tens_o, ones_o;

  bcd_convert_scheduler #(.NUM_REQ(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .data_i      (data_i),
    .ack_o       (ack_o),
    .busy_o      (busy_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_id_o    (out_id_o),
    .hundreds_o  (hundreds_o),
    .tens_o      (tens_o),
    .ones_o      (ones_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [11:0] digits;
  } exp_t;

  typedef struct {
    int          port;
    int          value;
    logic [11:0] digits;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  function automatic logic [11:0] model(input int v);
    logic [3:0] h, t, o;
    h = 4'(v / 100);
    t = 4'((v / 10) % 10);
    o = 4'(v % 10);
`ifdef BCD_SCHED_LZ_BLANK_EN
    if (v < 100) h = 4'hF;
    if (v < 10)  t = 4'hF;
`endif
    return {h, t, o};
  endfunction

  // Scoreboard consumer: one pop per accepted result
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0h required=none",
                 {out_id_o, hundreds_o, tens_o, ones_o});
      end else begin
        mon_e = sb.pop_front();
        check("result", 32'({out_id_o, hundreds_o, tens_o, ones_o}), 32'(mon_e));
      end
    end
  end

  task automatic wait_ack(input int port, input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (ack_o == '0 && cyc < 60);
    check(name, 32'(ack_o), 32'(1) << port);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic do_conv(input int port, input int value, input logic [11:0] digits);
    int c;
    data_i[port*8 +: 8] = 8'(value);
    req_i[port] = 1'b1;
    wait_ack(port, "ack", c);
    sb.push_back('{id: 2'(port), digits: digits});
    req_i[port] = 1'b0;
    drain();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, lat;
    int vals[4];
`ifdef BCD_SCHED_LZ_BLANK_EN
    vecs[0] = '{0, 0,   12'hFF0};
    vecs[1] = '{1, 7,   12'hFF7};
    vecs[2] = '{2, 105, 12'h105};
    vecs[3] = '{3, 40,  12'hF40};
    vecs[4] = '{1, 255, 12'h255};
    vecs[5] = '{2, 99,  12'hF99};
`else
    vecs[0] = '{0, 0,   12'h000};
    vecs[1] = '{1, 7,   12'h007};
    vecs[2] = '{2, 105, 12'h105};
    vecs[3] = '{3, 40,  12'h040};
    vecs[4] = '{1, 255, 12'h255};
    vecs[5] = '{2, 99,  12'h099};
`endif
    vals = '{10, 20, 30, 40};

    rst_n = 1'b0; req_i = '0; data_i = '0; out_ready_i = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ack",    32'(ack_o), 32'd0);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_valid",  32'(out_valid_o), 32'd0);
    check("rst_id",     32'(out_id_o), 32'd0);
    check("rst_digits", 32'({hundreds_o, tens_o, ones_o}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single request on port 2, result held until ready
    data_i[23:16] = 8'd255;
    req_i[2] = 1'b1;
    wait_ack(2, "single_ack", c);
    sb.push_back('{id: 2'd2, digits: model(255)});
    @(negedge clk);
    req_i[2] = 1'b0;
    check("ack_pulse", 32'(ack_o), 32'd0);
    lat = 1;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd8);
    repeat (3) begin
      @(negedge clk);
      check("hold", 32'({out_valid_o, out_id_o, hundreds_o, tens_o, ones_o}),
            32'({1'b1, 2'd2, model(255)}));
    end
    out_ready_i = 1'b1;
    drain();

    // All four requesting: round robin 0,1,2,3,0 at 10-cycle spacing
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) data_i[k*8 +: 8] = 8'(vals[k]);
    req_i = 4'hF;
    for (int n = 0; n < 5; n++) begin
      wait_ack(n % 4, "rr_ack", c);
      if (n > 0) check("rr_spacing", 32'(c), 32'd10);
      sb.push_back('{id: 2'(n % 4), digits: model(vals[n % 4])});
    end
    req_i = '0;
    drain();

    // Backpressure on port 1 (rr_ptr now 1) with port 3 waiting
    out_ready_i = 1'b0;
    data_i[15:8] = 8'd99;
    req_i[1] = 1'b1;
    wait_ack(1, "bp_ack", c);
    sb.push_back('{id: 2'd1, digits: model(99)});
    req_i[1] = 1'b0;
    data_i[31:24] = 8'd200;
    req_i[3] = 1'b1;
    lat = 0;
    while (!out_valid_o && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      check("bp_out", 32'({out_valid_o, out_id_o, hundreds_o, tens_o, ones_o}),
            32'({1'b1, 2'd1, model(99)}));
      check("bp_busy", 32'(busy_o), 32'd1);
      check("bp_noack", 32'(ack_o), 32'd0);
    end
    out_ready_i = 1'b1;
    wait_ack(3, "bp_next_ack", c);
    sb.push_back('{id: 2'd3, digits: model(200)});
    req_i[3] = 1'b0;
    drain();

    // Reset mid-conversion: put rr_ptr at 2, grant port 2, abort at iteration 4
    do_conv(1, 5, model(5));
    data_i = {8'd208, 8'd150, 8'd0, 8'd77};
    req_i = 4'b1101;
    wait_ack(2, "pre_rst_ack", c);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_rst", 32'({ack_o, busy_o, out_valid_o, out_id_o, hundreds_o, tens_o, ones_o}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ack(0, "post_rst_ack", c);
    sb.push_back('{id: 2'd0, digits: model(77)});
    req_i[0] = 1'b0;
    wait_ack(2, "post_rst_ack2", c);
    sb.push_back('{id: 2'd2, digits: model(150)});
    req_i[2] = 1'b0;
    wait_ack(3, "post_rst_ack3", c);
    sb.push_back('{id: 2'd3, digits: model(208)});
    req_i[3] = 1'b0;
    drain();

    // Vector table
    for (int i = 0; i < 6; i++) do_conv(vecs[i].port, vecs[i].value, vecs[i].digits);

    // Exhaustive sweep on port 0
    for (int v = 0; v < 256; v++) do_conv(0, v, model(v));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
